fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle core. It generates sequential fetch addresses, issues requests to a variable-latency instruction memory, and buffers returned words with their PCs in a small FIFO. It delivers them to the core over a valid/ready handshake. A branch or jump from the core redirects fetch, which flushes buffered and in-flight instructions.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential fetcher with one outstanding request and a PC/word FIFO.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to the core when empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        areset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   word_q [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic head_valid;
  logic rsp_ok;
  logic take;
  logic push;
  logic pop;
  logic slot_free;
  logic can_issue;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign head_valid = count != '0;
  assign rsp_ok     = state == WAIT && mem_rvalid && !redirect_valid;
  assign pop        = head_valid && instr_ready && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass      = rsp_ok && !head_valid && !areset;
  assign take        = bypass && instr_ready;
  assign instr_valid = head_valid || bypass;
  assign instr       = bypass ? mem_rdata : word_q[rd_ptr];
  assign instr_pc    = bypass ? req_pc : pc_q[rd_ptr];
`else
  assign take        = 1'b0;
  assign instr_valid = head_valid;
  assign instr       = word_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
`endif

  assign push = rsp_ok && !take;

  // a pop this cycle does not free a slot for the issue decision
  assign slot_free = (count + (AW+1)'(push)) < (AW+1)'(DEPTH);
  assign can_issue = state == IDLE || mem_rvalid;

  assign mem_req  = !areset && !redirect_valid && can_issue && slot_free;
  assign mem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      if (state == WAIT && !mem_rvalid) begin
        state <= DROP;
      end else if (state != IDLE && mem_rvalid) begin
        state <= IDLE;
      end
    end else begin
      if (mem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
        state    <= WAIT;
      end else if (state != IDLE && mem_rvalid) begin
        state <= IDLE;
      end
      if (push) begin
        pc_q[wr_ptr]   <= req_pc;
        word_q[wr_ptr] <= mem_rdata;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .areset(areset),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int deliveries = 0;

  // reference model: program-order queue of PCs waiting for the core
  logic [31:0] q[$];
  logic [31:0] m_pc = RPC;
  logic [31:0] m_raddr = '0;
  bit          m_out = 1'b0;
  bit          m_kill = 1'b0;

  // instruction memory with per-request latency
  bit          mpend = 1'b0;
  int          mwait = 0;
  logic [31:0] maddr = '0;
  int          lat = 1;
  bit          lat_rand = 1'b0;

  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;

  typedef struct {
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vnb;
    bit          vb;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, ~a[17:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    bit          resp;
    bit          byp;
    bit          take;
    bit          push;
    bit          ev;
    bit          er;
    logic [31:0] hp;
    resp = mem_rvalid && m_out && !m_kill && !areset && !redirect_valid;
    byp  = (BYP != 0) && resp && q.size() == 0;
    take = byp && instr_ready;
    push = resp && !take;
    ev   = q.size() != 0 || byp;
    er   = !areset && !redirect_valid && (!m_out || mem_rvalid)
           && (q.size() + int'(push)) < DEPTH;
    chk("mem_req", {31'b0, mem_req}, {31'b0, er});
    if (er) chk("mem_addr", mem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
    if (ev) begin
      hp = q.size() != 0 ? q[0] : m_raddr;
      chk("instr_pc", instr_pc, hp);
      chk("instr", instr, word(hp));
      if (instr_ready && !redirect_valid && !areset) deliveries++;
    end
    if (areset) begin
      q.delete();
      m_pc   = RPC;
      m_out  = 1'b0;
      m_kill = 1'b0;
    end else if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc & 32'hffff_fffc;
      if (m_out && !mem_rvalid) begin
        m_kill = 1'b1;
      end else begin
        m_out  = 1'b0;
        m_kill = 1'b0;
      end
    end else begin
      if (q.size() != 0 && instr_ready) void'(q.pop_front());
      if (push) q.push_back(m_raddr);
      if (mem_rvalid) begin
        m_out  = 1'b0;
        m_kill = 1'b0;
      end
      if (er) begin
        m_out   = 1'b1;
        m_kill  = 1'b0;
        m_raddr = m_pc;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_req   = mem_req;
    s_addr  = mem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    model_cycle();
    if (mem_req) begin
      mpend = 1'b1;
      maddr = mem_addr;
      mwait = lat_rand ? int'($urandom_range(1, 4)) : lat;
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (mpend) begin
      mwait--;
      if (mwait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word(maddr);
        mpend      = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    areset         = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    while (n < 2 || mpend) begin
      step();
      n++;
    end
    areset = 1'b0;
  endtask

  initial begin
    int nreq;
    int rcnt;
    int d0;
    bit found;
    bit ev;

    tbl[0]  = '{0, 1, 32'h100, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h104, 0, 1, 32'h100};
    tbl[2]  = '{0, 1, 32'h108, 1, 1, 32'h100};
    tbl[3]  = '{0, 1, 32'h10C, 1, 1, 32'h100};
    tbl[4]  = '{0, 0, 32'h0,   1, 1, 32'h100};
    tbl[5]  = '{0, 0, 32'h0,   1, 1, 32'h100};
    tbl[6]  = '{0, 0, 32'h0,   1, 1, 32'h100};
    tbl[7]  = '{0, 0, 32'h0,   1, 1, 32'h100};
    tbl[8]  = '{0, 0, 32'h0,   1, 1, 32'h100};
    tbl[9]  = '{0, 0, 32'h0,   1, 1, 32'h100};
    tbl[10] = '{1, 0, 32'h0,   1, 1, 32'h100};
    tbl[11] = '{1, 1, 32'h110, 1, 1, 32'h104};
    tbl[12] = '{1, 1, 32'h114, 1, 1, 32'h108};
    tbl[13] = '{1, 1, 32'h118, 1, 1, 32'h10C};
    tbl[14] = '{1, 1, 32'h11C, 1, 1, 32'h110};

    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;

    // stall, fill to DEPTH, then drain in order
    nreq = 0;
    for (int i = 0; i < 15; i++) begin
      instr_ready = tbl[i].rdy;
      step();
      if (i < 10 && s_req) nreq++;
      chk("tbl_req", {31'b0, s_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk("tbl_addr", s_addr, tbl[i].addr);
      ev = BYP != 0 ? tbl[i].vb : tbl[i].vnb;
      chk("tbl_valid", {31'b0, s_valid}, {31'b0, ev});
      if (ev) chk("tbl_pc", s_pc, tbl[i].pc);
    end
    chk("stall_req_count", nreq, 4);

    // throughput and first-word latency with L=1
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("tp_req", {31'b0, s_req}, 32'd1);
      chk("tp_addr", s_addr, RPC + 32'(4 * i));
      if (i == 1) chk("latency_valid", {31'b0, s_valid}, BYP);
      if (i >= 2 - BYP) begin
        chk("tp_valid", {31'b0, s_valid}, 32'd1);
        chk("tp_pc", s_pc, RPC + 32'(4 * (i - 2 + BYP)));
      end
    end

    // redirect with a request outstanding, L=3
    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    step();
    chk("rd_first_req", {31'b0, s_req}, 32'd1);
    chk("rd_first_addr", s_addr, RPC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    step();
    chk("rd_no_issue", {31'b0, s_req}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("rd_valid_r1", {31'b0, s_valid}, 32'd0);
    chk("rd_req_r1", {31'b0, s_req}, 32'd0);
    step();
    chk("rd_drop_valid", {31'b0, s_valid}, 32'd0);
    chk("rd_req_on_drop", {31'b0, s_req}, 32'd1);
    chk("rd_target_addr", s_addr, 32'h200);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_valid) begin
        chk("rd_first_pc", s_pc, 32'h200);
        found = 1'b1;
      end
    end
    chk("rd_delivered", {31'b0, found}, 32'd1);

    // redirect coinciding with a response and a pop, two entries held
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    repeat (3) step();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h340;
    step();
    chk("rp_valid_before", {31'b0, s_valid}, 32'd1);
    chk("rp_pc_before", s_pc, RPC);
    redirect_valid = 1'b0;
    step();
    chk("rp_flushed", {31'b0, s_valid}, 32'd0);
    chk("rp_req", {31'b0, s_req}, 32'd1);
    chk("rp_addr", s_addr, 32'h340);

    // reset mid-stream with three entries and a slow request outstanding
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    repeat (3) step();
    lat = 3;
    step();
    chk("mr_req_c3", {31'b0, s_req}, 32'd1);
    chk("mr_addr_c3", s_addr, RPC + 32'hC);
    areset = 1'b1;
    step();
    chk("mr_req_in_reset", {31'b0, s_req}, 32'd0);
    step();
    chk("mr_valid_after", {31'b0, s_valid}, 32'd0);
    chk("mr_req_after", {31'b0, s_req}, 32'd0);
    areset      = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("mr_restart_req", {31'b0, s_req}, 32'd1);
    chk("mr_restart_addr", s_addr, RPC);
    step();
    chk("mr_stale_ignored", {31'b0, s_valid}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_valid) begin
        chk("mr_first_pc", s_pc, RPC);
        found = 1'b1;
      end
    end
    chk("mr_delivered", {31'b0, found}, 32'd1);

    // randomized traffic against the reference model
    do_reset();
    lat_rand = 1'b1;
    rcnt = 0;
    d0 = deliveries;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (areset) begin
        rcnt++;
        if (rcnt >= 2 && !mpend) areset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        areset = 1'b1;
        rcnt = 0;
      end
      instr_ready    = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 24) == 0;
      redirect_pc    = $urandom;
    end
    chk("rand_progress", {31'b0, (deliveries - d0) > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
